// File: rtl/dot_product_stream.sv
// Streaming dot product: LEN A samples are stored, then LEN B samples are multiply-accumulated against them.
// The result is valid on the edge that accepts the last B; input stalls in HOLD until the result is consumed.
module dot_product_stream #(
   parameter int WIDTH  = 8,
   parameter int LEN    = 3,
   parameter bit SIGNED = 1'b0,
   localparam int OUT_W = 2*WIDTH + $clog2(LEN)
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] din,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] dout,
   output logic             busy
);
   localparam int IDX_W = (LEN > 1) ? $clog2(LEN) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LEN - 1);

   typedef enum logic [1:0] {LOAD_A, MAC_B, HOLD} state_t;

   state_t           state_q;
   logic [IDX_W-1:0] idx_q;
   logic [OUT_W-1:0] acc_q;
   logic [OUT_W-1:0] dout_q;
   logic             out_vld_q;
   logic [WIDTH-1:0] a_q [LEN];

   logic             accept;
   logic             consume;
   logic             last;
   logic             a_wr;
   logic [IDX_W-1:0] a_wr_idx;
   logic [OUT_W-1:0] a_ext;
   logic [OUT_W-1:0] b_ext;
   logic [OUT_W-1:0] prod_d;
   logic [OUT_W-1:0] sum_d;

   // Operands are widened to the full result width, so the low OUT_W bits of the
   // product are exact for both unsigned and two's-complement operands.
   function automatic logic [OUT_W-1:0] extend(input logic [WIDTH-1:0] x);
      return {{(OUT_W-WIDTH){SIGNED && x[WIDTH-1]}}, x};
   endfunction

   always_comb begin
      in_ready = 1'b0;
      if (resetn && !clear) begin
         in_ready = (state_q == HOLD) ? out_ready : 1'b1;
      end
   end

   assign accept  = in_valid && in_ready;
   assign consume = out_vld_q && out_ready;
   assign last    = (idx_q == IDX_LAST);

   assign a_ext  = extend(a_q[idx_q]);
   assign b_ext  = extend(din);
   assign prod_d = a_ext * b_ext;
   assign sum_d  = (idx_q == '0) ? prod_d : acc_q + prod_d;

   // A sample accepted in HOLD is the first A element of the next operation.
   assign a_wr     = accept && (state_q != MAC_B);
   assign a_wr_idx = (state_q == HOLD) ? '0 : idx_q;

   always_ff @(posedge clk) begin
      if (a_wr) begin
         a_q[a_wr_idx] <= din;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= LOAD_A;
         idx_q     <= '0;
         acc_q     <= '0;
         dout_q    <= '0;
         out_vld_q <= 1'b0;
      end else if (clear) begin
         state_q   <= LOAD_A;
         idx_q     <= '0;
         acc_q     <= '0;
         out_vld_q <= 1'b0;
      end else begin
         case (state_q)
            LOAD_A: begin
               if (accept) begin
                  idx_q <= last ? '0 : idx_q + 1'b1;
                  if (last) begin
                     state_q <= MAC_B;
                  end
               end
            end
            MAC_B: begin
               if (accept) begin
                  acc_q <= sum_d;
                  idx_q <= last ? '0 : idx_q + 1'b1;
                  if (last) begin
                     dout_q    <= sum_d;
                     out_vld_q <= 1'b1;
                     state_q   <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (consume) begin
                  out_vld_q <= 1'b0;
                  if (!accept) begin
                     state_q <= LOAD_A;
                     idx_q   <= '0;
                  end else if (LEN == 1) begin
                     state_q <= MAC_B;
                     idx_q   <= '0;
                  end else begin
                     state_q <= LOAD_A;
                     idx_q   <= IDX_W'(1);
                  end
               end
            end
            default: begin
               state_q <= LOAD_A;
               idx_q   <= '0;
            end
         endcase
      end
   end

   assign busy      = (state_q == MAC_B) || ((state_q == LOAD_A) && (idx_q != '0));
   assign out_valid = out_vld_q;
   assign dout      = dout_q;

endmodule

// File: tb/tb_dot_product_stream.sv
// Bench for dot_product_stream: an unsigned LEN=3 instance and a signed LEN=4 instance,
// scoreboarded against a plain-arithmetic dot-product model.
module tb_dot_product_stream;
   logic        clk = 1'b0;
   logic        resetn;
   logic        clr   [2];
   logic        iv    [2];
   logic        ir    [2];
   logic        ov    [2];
   logic        ordy  [2];
   logic        bsy   [2];
   logic [7:0]  din   [2];
   logic [17:0] dout  [2];

   int     nchk = 0;
   int     npass = 0;
   int     cyc = 0;
   int     acc_cyc;
   int     cons_cyc [2];
   int     last_cons [2];
   bit     held [2];
   logic [17:0] held_val [2];
   longint expq [2][$];
   bit     rnd_bp = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dot_product_stream u_dut0 (
      .clk(clk), .resetn(resetn), .clear(clr[0]),
      .in_valid(iv[0]), .in_ready(ir[0]), .din(din[0]),
      .out_valid(ov[0]), .out_ready(ordy[0]), .dout(dout[0]), .busy(bsy[0])
   );

   dot_product_stream #(.WIDTH(8), .LEN(4), .SIGNED(1'b1)) u_dut1 (
      .clk(clk), .resetn(resetn), .clear(clr[1]),
      .in_valid(iv[1]), .in_ready(ir[1]), .din(din[1]),
      .out_valid(ov[1]), .out_ready(ordy[1]), .dout(dout[1]), .busy(bsy[1])
   );

   task automatic chk(input string tag, input longint got, input longint exp);
      nchk++;
      if (got == exp) npass++;
      else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
   endtask

   // Reference: sum of A[i]*B[i] over the vector length, wrapped to 18 bits.
   function automatic longint ref_dot(input int s, input int v[8]);
      longint sum, a, b;
      int n;
      n = (s == 0) ? 3 : 4;
      sum = 0;
      for (int i = 0; i < n; i++) begin
         a = v[i] & 255;
         b = v[n+i] & 255;
         if (s == 1) begin
            if (a > 127) a -= 256;
            if (b > 127) b -= 256;
         end
         sum += a * b;
      end
      return sum & 64'h3FFFF;
   endfunction

   task automatic idle(input int s, input int n);
      iv[s] = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input int s, input int v);
      bit ok;
      ok = 1'b0;
      iv[s]  = 1'b1;
      din[s] = 8'(v);
      for (int k = 0; k < 200 && !ok; k++) begin
         @(negedge clk);
         ok = ir[s];
         if (ok) acc_cyc = cyc;
         @(posedge clk);
         #1;
      end
      chk("accept", ok, 1);
   endtask

   task automatic run_op(input int s, input int v[8], input bit keep, input bit gaps);
      int n;
      n = (s == 0) ? 6 : 8;
      expq[s].push_back(ref_dot(s, v));
      for (int i = 0; i < n; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) idle(s, $urandom_range(1, 3));
         push(s, v[i]);
      end
      if (!keep) iv[s] = 1'b0;
   endtask

   always @(negedge clk) begin
      for (int s = 0; s < 2; s++) begin
         if (ov[s] && !ordy[s]) begin
            chk("hold_in_ready", ir[s], 0);
            if (held[s]) chk("hold_stable", dout[s], held_val[s]);
            held[s] = 1'b1;
            held_val[s] = dout[s];
         end else begin
            held[s] = 1'b0;
         end
         if (ov[s] && ordy[s]) begin
            chk("pending_exp", expq[s].size() > 0, 1);
            if (expq[s].size() > 0) chk("dout", dout[s], expq[s].pop_front());
            last_cons[s] = cons_cyc[s];
            cons_cyc[s]  = cyc;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rnd_bp) begin
            for (int s = 0; s < 2; s++) ordy[s] = 1'($urandom_range(0, 1));
         end
      end
   end

   initial begin
      int v[8];
      resetn = 1'b0;
      for (int s = 0; s < 2; s++) begin
         clr[s] = 1'b0; iv[s] = 1'b0; din[s] = '0; ordy[s] = 1'b1;
         held[s] = 1'b0; cons_cyc[s] = 0; last_cons[s] = 0;
      end
      @(negedge clk);
      chk("rst_in_ready", ir[0], 0);
      chk("rst_out_valid", ov[0], 0);
      chk("rst_dout", dout[0], 0);
      chk("rst_busy", bsy[0], 0);
      chk("rst_in_ready1", ir[1], 0);
      @(posedge clk); #1;
      resetn = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", ir[0], 1);
      @(posedge clk); #1;

      // All-zero operation and first-result latency
      run_op(0, '{0, 0, 0, 0, 0, 0, 0, 0}, 0, 0);
      @(negedge clk);
      chk("lat_out_valid", ov[0], 1);
      chk("done_busy", bsy[0], 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("consumed_out_valid", ov[0], 0);
      @(posedge clk); #1;

      // Back-to-back operations, no bubble
      run_op(0, '{1, 2, 3, 4, 5, 6, 0, 0}, 1, 0);
      run_op(0, '{7, 8, 9, 1, 2, 3, 0, 0}, 0, 0);
      idle(0, 3);
      chk("b2b_spacing", cons_cyc[0] - last_cons[0], 6);

      // Result held under backpressure, next op starts on the consume cycle
      ordy[0] = 1'b0;
      run_op(0, '{255, 255, 255, 255, 255, 255, 0, 0}, 1, 0);
      din[0] = 8'd1;
      repeat (5) begin
         @(negedge clk);
         chk("bp_out_valid", ov[0], 1);
         chk("bp_in_ready", ir[0], 0);
         chk("bp_dout", dout[0], 195075);
         @(posedge clk); #1;
      end
      ordy[0] = 1'b1;
      expq[0].push_back(ref_dot(0, '{1, 2, 3, 4, 5, 6, 0, 0}));
      push(0, 1);
      chk("start_on_consume", acc_cyc, cons_cyc[0]);
      for (int i = 2; i <= 6; i++) push(0, i);
      idle(0, 3);

      // Input gaps
      expq[0].push_back(ref_dot(0, '{1, 2, 3, 4, 5, 6, 0, 0}));
      for (int i = 1; i <= 3; i++) push(0, i);
      iv[0] = 1'b0;
      @(negedge clk);
      chk("gap_busy", bsy[0], 1);
      chk("gap_out_valid", ov[0], 0);
      @(posedge clk); #1;
      idle(0, 1);
      for (int i = 4; i <= 6; i++) push(0, i);
      idle(0, 3);

      // Clear mid-operation
      for (int i = 0; i < 4; i++) push(0, 1);
      clr[0] = 1'b1; din[0] = 8'd9;
      @(negedge clk);
      chk("clear_in_ready", ir[0], 0);
      @(posedge clk); #1;
      clr[0] = 1'b0; iv[0] = 1'b0;
      @(negedge clk);
      chk("clear_busy", bsy[0], 0);
      chk("clear_out_valid", ov[0], 0);
      @(posedge clk); #1;
      run_op(0, '{2, 2, 2, 3, 3, 3, 0, 0}, 0, 0);
      idle(0, 3);

      // Asynchronous reset mid-operation
      for (int i = 1; i <= 4; i++) push(0, i);
      iv[0] = 1'b0;
      resetn = 1'b0;
      #1;
      chk("arst_out_valid", ov[0], 0);
      chk("arst_dout", dout[0], 0);
      chk("arst_busy", bsy[0], 0);
      chk("arst_in_ready", ir[0], 0);
      @(posedge clk); @(posedge clk); #1;
      resetn = 1'b1;
      run_op(0, '{1, 2, 3, 4, 5, 6, 0, 0}, 0, 0);
      idle(0, 3);

      // Signed instance, extremes and negative result
      run_op(1, '{-128, -1, 2, 127, -128, 5, -3, 1}, 0, 0);
      @(negedge clk);
      chk("s_lat_out_valid", ov[1], 1);
      @(posedge clk); #1;
      run_op(1, '{-1, 0, 0, 0, 127, 0, 0, 0}, 0, 0);
      idle(1, 3);

      // Randomised operations with gaps and random backpressure
      rnd_bp = 1'b1;
      for (int s = 0; s < 2; s++) begin
         for (int op = 0; op < 15; op++) begin
            for (int i = 0; i < 8; i++) begin
               case ($urandom_range(0, 5))
                  0: v[i] = 0;
                  1: v[i] = 255;
                  2: v[i] = 128;
                  3: v[i] = 127;
                  default: v[i] = int'($urandom_range(0, 255));
               endcase
            end
            run_op(s, v, 1'($urandom_range(0, 1)), 1);
         end
         iv[s] = 1'b0;
      end
      rnd_bp = 1'b0;
      @(posedge clk); #1;
      ordy[0] = 1'b1; ordy[1] = 1'b1;
      for (int k = 0; k < 300 && (expq[0].size() > 0 || expq[1].size() > 0); k++) @(posedge clk);
      #1;
      chk("drain0", expq[0].size(), 0);
      chk("drain1", expq[1].size(), 0);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end
endmodule

// File: doc/dot_product_stream.md
Name: dot_product_stream

Overview:
Streaming integer dot-product engine and the parametrised successor of the fixed 3-element, 8-bit dot-product model. It accepts one sample per cycle on a valid/ready input stream: the first LEN samples form vector A and the next LEN samples form vector B. It multiply-accumulates B against the stored A and presents the result on a valid/ready output stream. It sits between a sample-producing front end and a result consumer that may apply backpressure.

Parameters:
WIDTH, 8, sample width in bits.
LEN, 3, vector length (LEN >= 1); one operation consumes 2*LEN samples.
SIGNED, 0, 0 = unsigned operands; 1 = two's-complement operands and result.
OUT_W, 2*WIDTH + $clog2(LEN), result width (18 at defaults); derived, not overridden.

Ports:
clk  input  1  rising-edge clock
resetn  input  1  asynchronous active-low reset
clear  input  1  synchronous abort of the current operation
in_valid  input  1  din carries a sample
in_ready  output  1  block accepts din this cycle
din  input  WIDTH  sample (A elements first, then B elements)
out_valid  output  1  dout holds a completed result
out_ready  input  1  consumer accepts dout
dout  output  OUT_W  dot product
busy  output  1  at least one sample of the current operation accepted

Behaviour:
- Accept = in_valid && in_ready; consume = out_valid && out_ready.
- State machine: LOAD_A, MAC_B, HOLD. Index counter idx runs 0..LEN-1.
- LOAD_A:
  - in_ready=1.
  - On accept: A[idx] <= din; idx++.
  - On accept with idx==LEN-1: idx <= 0, go to MAC_B.
- MAC_B:
  - in_ready=1.
  - On accept: acc <= acc + A[idx]*din; idx++. The first B accept loads acc with the product (no prior clear cycle needed).
  - On accept with idx==LEN-1: dout <= final sum, out_valid <= 1, idx <= 0, go to HOLD.
- Latency: out_valid rises on the edge that accepts the last B sample. Result is visible one cycle after the last B sample is presented with in_valid=1. With continuous input, 2*LEN edges after the first sample.
- HOLD:
  - out_valid=1; dout stable until consume.
  - in_ready = out_ready.
  - On consume: out_valid <= 0. Go to LOAD_A, or, if a sample is accepted in the same cycle, store it as A[0], set idx=1 and go to LOAD_A (or MAC_B when LEN==1). Back-to-back operations therefore have no bubble.
  - While out_ready=0: in_ready=0 and no sample is lost.
- in_valid=0 cycles anywhere: state, idx and acc hold.
- Arithmetic:
  - SIGNED=0: operands zero-extended.
  - SIGNED=1: operands sign-extended; products and acc are signed; dout is two's complement.
  - OUT_W never overflows for any input.
- busy = 1 in LOAD_A/MAC_B when idx>0 or state==MAC_B; busy = 0 in HOLD and when idle.
- clear, when 1 at a clock edge:
  - Go to LOAD_A; idx <= 0, acc <= 0, out_valid <= 0.
  - Any pending result is discarded and any sample accepted that cycle is dropped.
  - in_ready is forced 0 while clear=1.
  - clear has priority over all other events.
- Reset (asynchronous, resetn=0):
  - State LOAD_A, idx=0, acc=0.
  - Outputs: dout=0, out_valid=0, busy=0; in_ready=0 while resetn=0, then 1 from the first cycle after release.
  - A storage need not be reset.
  - Reset mid-operation discards the partial operation with the same effect as clear.
- A elements are retained after an operation but never reused; every operation reloads A.

Test Plan:
- Defaults, out_ready=1, 6 samples of 0 -> out_valid=1 one cycle after the 6th sample presented, dout=0.
- Defaults, back-to-back [1,2,3,4,5,6] then [7,8,9,1,2,3] with in_valid and out_ready held 1 -> dout=32, then dout=50 exactly 6 cycles later, no bubble.
- Defaults, [255,255,255,255,255,255] with out_ready=0 for 5 cycles after completion -> dout=195075 held stable, in_ready=0 throughout; next operation starts on the consume cycle.
- SIGNED=1, WIDTH=8, LEN=4: A=[-128,-1,2,127], B=[-128,5,-3,1] -> dout=16384-5-6+127=16500; repeat with A=[-1,0,0,0], B=[127,0,0,0] -> dout=-127 (OUT_W=18 two's complement).
- Defaults, in_valid gaps: 3 samples, 2 idle cycles, 3 samples of [1,2,3,4,5,6] -> dout=32; clear pulsed after 4 samples, then 6 samples [2,2,2,3,3,3] -> dout=18, with no out_valid before that.
- Reset asserted after 4 samples mid-operation -> out_valid=0, dout=0, busy=0 immediately; after release, [1,2,3,4,5,6] -> dout=32.
